// File: rtl/decoder_scan_ctrl.sv
// Channel scan sequencer for the 3-to-8 decoder: walks the enabled channels of
// a mask, holds each for a programmable dwell, and drops en between channels
// so the decoder select never changes while its outputs are enabled.
//
//  state | meaning
//  IDLE  | waiting for start; en=0, busy=0
//  DWELL | channel sel enabled; counting dwell cycles
//  BLANK | en low between channels; sel still holds the old channel
module decoder_scan_ctrl #(
    parameter int DW        = 8,
    parameter int BLANK_CYC = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          cont,
    input  logic [7:0]    ch_mask,
    input  logic [DW-1:0] dwell,
    output logic [2:0]    sel,
    output logic          en,
    output logic          busy,
    output logic          frame,
    output logic          done
);

    localparam int BW = (BLANK_CYC < 2) ? 1 : $clog2(BLANK_CYC + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        BLANK = 2'd2
    } state_t;

    state_t        state, state_d;
    logic [7:0]    mask_q, mask_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic          cont_q, cont_d;
    logic [DW-1:0] cnt, cnt_d;
    logic [BW-1:0] bcnt, bcnt_d;
    logic [2:0]    sel_d;
    logic          en_d, busy_d, frame_d, done_d;

    logic [DW-1:0] dwell_eff;
    logic [2:0]    first_idx;
    logic [2:0]    next_idx;
    logic [2:0]    scan_idx;
    logic          next_found;
    logic          wrap;
    logic          advance;

    // A latched dwell of zero behaves as one cycle.
    assign dwell_eff = (dwell_q == '0) ? DW'(1) : dwell_q;

    // Lowest enabled channel of the incoming mask, used when a sweep starts.
    always_comb begin
        first_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (ch_mask[i]) first_idx = 3'(i);
        end
    end

    // Next enabled channel strictly above sel, wrapping 7->0; a full turn
    // lands back on sel itself, which covers single-channel masks.
    always_comb begin
        next_idx   = sel;
        scan_idx   = sel;
        next_found = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            scan_idx = sel + 3'(i);
            if (!next_found && mask_q[scan_idx]) begin
                next_idx   = scan_idx;
                next_found = 1'b1;
            end
        end
        wrap = (next_idx <= sel);
    end

    // Next-state and next-output logic; all outputs are registered below.
    always_comb begin
        state_d = state;
        sel_d   = sel;
        en_d    = en;
        busy_d  = busy;
        frame_d = 1'b0;
        done_d  = 1'b0;
        cnt_d   = cnt;
        bcnt_d  = bcnt;
        mask_d  = mask_q;
        dwell_d = dwell_q;
        cont_d  = cont_q;
        advance = 1'b0;

        case (state)
            IDLE: begin
                en_d   = 1'b0;
                busy_d = 1'b0;
                if (start && !stop && (ch_mask != 8'd0)) begin
                    mask_d  = ch_mask;
                    dwell_d = dwell;
                    cont_d  = cont;
                    sel_d   = first_idx;
                    state_d = DWELL;
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = DW'(1);
                end
            end
            DWELL: begin
                if (stop) begin
                    state_d = IDLE;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                end else if (cnt == dwell_eff) begin
                    if (BLANK_CYC == 0) begin
                        advance = 1'b1;
                    end else begin
                        state_d = BLANK;
                        en_d    = 1'b0;
                        bcnt_d  = BW'(1);
                    end
                end else begin
                    cnt_d = cnt + DW'(1);
                end
            end
            BLANK: begin
                if (stop) begin
                    state_d = IDLE;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                end else if (bcnt == BW'(BLANK_CYC)) begin
                    advance = 1'b1;
                end else begin
                    bcnt_d = bcnt + BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                en_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        // Moving to the next channel: a wrap marks the end of a sweep.
        if (advance) begin
            if (wrap && !cont_q) begin
                state_d = IDLE;
                en_d    = 1'b0;
                busy_d  = 1'b0;
                frame_d = 1'b1;
                done_d  = 1'b1;
            end else begin
                frame_d = wrap;
                sel_d   = next_idx;
                state_d = DWELL;
                en_d    = 1'b1;
                cnt_d   = DW'(1);
            end
        end
    end

    // State, latched configuration, counters and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sel     <= 3'd0;
            en      <= 1'b0;
            busy    <= 1'b0;
            frame   <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
            bcnt    <= '0;
            mask_q  <= 8'd0;
            dwell_q <= '0;
            cont_q  <= 1'b0;
        end else begin
            state   <= state_d;
            sel     <= sel_d;
            en      <= en_d;
            busy    <= busy_d;
            frame   <= frame_d;
            done    <= done_d;
            cnt     <= cnt_d;
            bcnt    <= bcnt_d;
            mask_q  <= mask_d;
            dwell_q <= dwell_d;
            cont_q  <= cont_d;
        end
    end

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Directed bench for decoder_scan_ctrl: one instance with one blanking cycle,
// one with blanking disabled, sharing all inputs.
module tb_decoder_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       cont;
    logic [7:0] ch_mask;
    logic [7:0] dwell;

    logic [2:0] sel_b, sel_n;
    logic       en_b, en_n, busy_b, busy_n, frame_b, frame_n, done_b, done_n;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    decoder_scan_ctrl #(.DW(8), .BLANK_CYC(1)) dut_b (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .cont(cont),
        .ch_mask(ch_mask), .dwell(dwell),
        .sel(sel_b), .en(en_b), .busy(busy_b), .frame(frame_b), .done(done_b)
    );

    decoder_scan_ctrl #(.DW(8), .BLANK_CYC(0)) dut_n (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .cont(cont),
        .ch_mask(ch_mask), .dwell(dwell),
        .sel(sel_n), .en(en_n), .busy(busy_n), .frame(frame_n), .done(done_n)
    );

    // Packed view {sel, en, busy, frame, done} of each instance.
    function automatic logic [6:0] vec_b();
        return {sel_b, en_b, busy_b, frame_b, done_b};
    endfunction

    function automatic logic [6:0] vec_n();
        return {sel_n, en_n, busy_n, frame_n, done_n};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic pulse_start(input logic [7:0] m, input logic [7:0] d, input logic c);
        ch_mask = m;
        dwell   = d;
        cont    = c;
        start   = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Expected {sel,en,busy,frame,done} for the single sweep over 8'b1000_0101.
    logic [6:0] exp_single [11] = '{
        {3'd0, 4'b1100}, {3'd0, 4'b1100}, {3'd0, 4'b0100},
        {3'd2, 4'b1100}, {3'd2, 4'b1100}, {3'd2, 4'b0100},
        {3'd7, 4'b1100}, {3'd7, 4'b1100}, {3'd7, 4'b0100},
        {3'd7, 4'b0011}, {3'd7, 4'b0000}
    };

    initial begin
        int en_cycles;
        bit saw_done;

        rst = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0;
        ch_mask = 8'd0; dwell = 8'd0;

        // Reset with random inputs on the other pins.
        for (int i = 0; i < 2; i++) begin
            start   = 1'($urandom);
            stop    = 1'($urandom);
            cont    = 1'($urandom);
            ch_mask = 8'($urandom);
            dwell   = 8'($urandom);
            step();
        end
        chk("reset_b", 32'(vec_b()), 32'd0);
        chk("reset_n", 32'(vec_n()), 32'd0);
        rst = 1'b0; start = 1'b0; stop = 1'b0;
        step();

        // Single sweep with one blanking cycle.
        do_reset();
        pulse_start(8'b1000_0101, 8'd2, 1'b0);
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("single_c%0d", i + 1), 32'(vec_b()), 32'(exp_single[i]));
            step();
        end

        // Continuous sweep over one channel with dwell 0.
        do_reset();
        pulse_start(8'h80, 8'd0, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            logic [6:0] e;
            if (k % 2 == 1) e = {3'd7, 1'b1, 1'b1, (k >= 3) ? 1'b1 : 1'b0, 1'b0};
            else            e = {3'd7, 4'b0100};
            chk($sformatf("cont_c%0d", k), 32'(vec_b()), 32'(e));
            step();
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("cont_stop", 32'(vec_b()), 32'({3'd7, 4'b0000}));

        // Stop on the third dwell cycle of channel 4 (dwell cycles 25..29).
        do_reset();
        pulse_start(8'hFF, 8'd5, 1'b0);
        for (int i = 1; i < 27; i++) step();
        chk("stop_pre", 32'(vec_b()), 32'({3'd4, 4'b1100}));
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_now", 32'(vec_b()), 32'({3'd4, 4'b0000}));
        step(); step();
        chk("stop_after", 32'(vec_b()), 32'({3'd4, 4'b0000}));

        // Ignored starts: empty mask, start while busy with a changed mask,
        // and start together with stop.
        do_reset();
        pulse_start(8'h00, 8'd3, 1'b1);
        chk("ign_mask0", 32'(vec_b()), 32'd0);
        step();
        chk("ign_mask0_b", 32'(vec_b()), 32'd0);
        pulse_start(8'h05, 8'd1, 1'b0);
        chk("busy_c1", 32'(vec_b()), 32'({3'd0, 4'b1100}));
        step();
        chk("busy_c2", 32'(vec_b()), 32'({3'd0, 4'b0100}));
        pulse_start(8'h02, 8'd9, 1'b1);
        chk("busy_c3", 32'(vec_b()), 32'({3'd2, 4'b1100}));
        step();
        chk("busy_c4", 32'(vec_b()), 32'({3'd2, 4'b0100}));
        step();
        chk("busy_c5", 32'(vec_b()), 32'({3'd2, 4'b0011}));
        stop = 1'b1;
        pulse_start(8'hFF, 8'd1, 1'b0);
        stop = 1'b0;
        chk("start_stop", 32'(vec_b()), 32'({3'd2, 4'b0000}));

        // No blanking: en stays high across the channel change.
        do_reset();
        pulse_start(8'h03, 8'd1, 1'b0);
        chk("noblank_c1", 32'(vec_n()), 32'({3'd0, 4'b1100}));
        step();
        chk("noblank_c2", 32'(vec_n()), 32'({3'd1, 4'b1100}));
        step();
        chk("noblank_c3", 32'(vec_n()), 32'({3'd1, 4'b0011}));

        // Reset mid-sweep aborts with no pulses.
        do_reset();
        pulse_start(8'h0F, 8'd3, 1'b1);
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_b", 32'(vec_b()), 32'd0);
        chk("rst_mid_n", 32'(vec_n()), 32'd0);

        // Maximum dwell on one channel, blanking disabled.
        do_reset();
        pulse_start(8'h01, 8'hFF, 1'b0);
        en_cycles = 0;
        saw_done  = 1'b0;
        for (int i = 0; i < 300 && !saw_done; i++) begin
            if (en_n) en_cycles++;
            if (done_n) saw_done = 1'b1;
            step();
        end
        chk("maxdwell_done", 32'(saw_done), 32'd1);
        chk("maxdwell_len", 32'(en_cycles), 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
